watch_bcd_ext: RTL

Parametrised successor to the team's 4-digit HH:MM watch. It keeps a BCD time of day (hours, minutes, seconds) and advances it from an internal clock-enable prescaler instead of a rippled divided clock. It adds a 12/24-hour mode, a validated set-time load, a run/stop controller and a day-rollover pulse. It sits between the board clock and the 7-segment display driver.

---
 rtl/watch_bcd_ext.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/watch_bcd_ext.sv
// BCD hh:mm:ss watch advanced by a clock-enable prescaler, with 12/24-hour mode,
// validated set-time and IDLE/RUN/HOLD control. Define WATCH_ALARM_EN to add the hh:mm alarm.
module watch_bcd_ext #(
    parameter int TICK_DIV = 50000000,
    parameter int HOUR_24  = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start_resume,
    input  logic       stop,
    input  logic       set_time,
    input  logic [7:0] set_hr,
    input  logic [7:0] set_min,
    output logic [3:0] hr1,
    output logic [3:0] hr0,
    output logic [3:0] min1,
    output logic [3:0] min0,
    output logic [3:0] sec1,
    output logic [3:0] sec0,
    output logic       pm,
    output logic       running,
    output logic       set_err,
    output logic       day_tick,
    input  logic [7:0] alarm_hr,
    input  logic [7:0] alarm_min,
    input  logic       alarm_set,
    input  logic       alarm_ack,
    output logic       alarm
);
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PS_LAST = PW'(TICK_DIV - 1);
    localparam logic [7:0] RST_HR = (HOUR_24 != 0) ? 8'h00 : 8'h12;

    typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   ps_q, ps_d;
    logic [3:0]      hr1_q, hr0_q, min1_q, min0_q, sec1_q, sec0_q;
    logic [3:0]      hr1_d, hr0_d, min1_d, min0_d, sec1_d, sec0_d;
    logic            pm_q, pm_d, set_err_q, set_err_d, day_tick_q, day_tick_d;

    logic [3:0]      a_h1, a_h0, a_m1, a_m0, a_s1, a_s0;
    logic            a_pm, a_mid, tick;

    function automatic logic valid_time(input logic [7:0] hr, input logic [7:0] mn);
        logic ok;
        ok = (hr[7:4] <= 4'd9) && (hr[3:0] <= 4'd9) && (mn[7:4] <= 4'd5) && (mn[3:0] <= 4'd9);
        if (HOUR_24 != 0)
            ok = ok && (hr <= 8'h23);
        else
            ok = ok && (hr >= 8'h01) && (hr <= 8'h12);
        return ok;
    endfunction

    // One-second successor of the current time; every carry resolves here in one cycle.
    always_comb begin
        a_h1 = hr1_q; a_h0 = hr0_q; a_m1 = min1_q; a_m0 = min0_q;
        a_s1 = sec1_q; a_s0 = sec0_q; a_pm = pm_q; a_mid = 1'b0;
        if (sec0_q != 4'd9) a_s0 = sec0_q + 4'd1;
        else begin
            a_s0 = 4'd0;
            if (sec1_q != 4'd5) a_s1 = sec1_q + 4'd1;
            else begin
                a_s1 = 4'd0;
                if (min0_q != 4'd9) a_m0 = min0_q + 4'd1;
                else begin
                    a_m0 = 4'd0;
                    if (min1_q != 4'd5) a_m1 = min1_q + 4'd1;
                    else begin
                        a_m1 = 4'd0;
                        if ((HOUR_24 != 0) && ({hr1_q, hr0_q} == 8'h23)) begin
                            a_h1 = 4'd0; a_h0 = 4'd0; a_mid = 1'b1;
                        end else if ((HOUR_24 == 0) && ({hr1_q, hr0_q} == 8'h12)) begin
                            a_h1 = 4'd0; a_h0 = 4'd1;
                        end else begin
                            if (hr0_q == 4'd9) begin
                                a_h1 = hr1_q + 4'd1; a_h0 = 4'd0;
                            end else begin
                                a_h0 = hr0_q + 4'd1;
                            end
                            // 11 -> 12 flips AM/PM; leaving PM is the midnight rollover.
                            if ((HOUR_24 == 0) && ({hr1_q, hr0_q} == 8'h11)) begin
                                a_pm = ~pm_q; a_mid = pm_q;
                            end
                        end
                    end
                end
            end
        end
    end

`ifdef WATCH_ALARM_EN
    logic [7:0] al_hr_q, al_hr_d, al_min_q, al_min_d;
    logic       alarm_q, alarm_d;
`else
    logic       unused_alarm;
    assign unused_alarm = ^{alarm_hr, alarm_min, alarm_set, alarm_ack};
`endif

    always_comb begin
        state_d = state_q; ps_d = ps_q;
        hr1_d = hr1_q; hr0_d = hr0_q; min1_d = min1_q; min0_d = min0_q;
        sec1_d = sec1_q; sec0_d = sec0_q; pm_d = pm_q;
        set_err_d = 1'b0; day_tick_d = 1'b0; tick = 1'b0;
        if (state_q == RUN) begin
            if (stop) state_d = HOLD;
            else if (ps_q == PS_LAST) begin
                ps_d = '0; tick = 1'b1;
            end else begin
                ps_d = ps_q + 1'b1;
            end
        end else begin
            if (start_resume && !stop) state_d = RUN;
            if (set_time) begin
                if (valid_time(set_hr, set_min)) begin
                    {hr1_d, hr0_d} = set_hr; {min1_d, min0_d} = set_min;
                    sec1_d = 4'd0; sec0_d = 4'd0; pm_d = 1'b0; ps_d = '0;
                end else begin
                    set_err_d = 1'b1;
                end
            end
        end
        if (tick) begin
            hr1_d = a_h1; hr0_d = a_h0; min1_d = a_m1; min0_d = a_m0;
            sec1_d = a_s1; sec0_d = a_s0; pm_d = a_pm; day_tick_d = a_mid;
        end
`ifdef WATCH_ALARM_EN
        al_hr_d = al_hr_q; al_min_d = al_min_q; alarm_d = alarm_q;
        if (alarm_set) begin
            if (valid_time(alarm_hr, alarm_min)) begin
                al_hr_d = alarm_hr; al_min_d = alarm_min;
            end else begin
                set_err_d = 1'b1;
            end
        end
        // A match on this advance outranks a simultaneous acknowledge.
        if (tick && (a_s1 == 4'd0) && (a_s0 == 4'd0) &&
            ({a_h1, a_h0} == al_hr_q) && ({a_m1, a_m0} == al_min_q))
            alarm_d = 1'b1;
        else if (alarm_ack)
            alarm_d = 1'b0;
`endif
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE; ps_q <= '0;
            hr1_q <= RST_HR[7:4]; hr0_q <= RST_HR[3:0];
            min1_q <= 4'd0; min0_q <= 4'd0; sec1_q <= 4'd0; sec0_q <= 4'd0;
            pm_q <= 1'b0; set_err_q <= 1'b0; day_tick_q <= 1'b0;
`ifdef WATCH_ALARM_EN
            al_hr_q <= RST_HR; al_min_q <= 8'h00; alarm_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d; ps_q <= ps_d;
            hr1_q <= hr1_d; hr0_q <= hr0_d; min1_q <= min1_d; min0_q <= min0_d;
            sec1_q <= sec1_d; sec0_q <= sec0_d;
            pm_q <= pm_d; set_err_q <= set_err_d; day_tick_q <= day_tick_d;
`ifdef WATCH_ALARM_EN
            al_hr_q <= al_hr_d; al_min_q <= al_min_d; alarm_q <= alarm_d;
`endif
        end
    end

    assign hr1 = hr1_q;   assign hr0 = hr0_q;
    assign min1 = min1_q; assign min0 = min0_q;
    assign sec1 = sec1_q; assign sec0 = sec0_q;
    assign pm = pm_q;
    assign running = (state_q == RUN);
    assign set_err = set_err_q;
    assign day_tick = day_tick_q;
`ifdef WATCH_ALARM_EN
    assign alarm = alarm_q;
`else
    assign alarm = 1'b0;
`endif
endmodule
